// File: rtl/mult_shift_reg.sv
// Universal shift register for the shift-add multiplier datapath.
// Parallel load, single-step shifts and a counted multi-step shift sequencer.
module mult_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] db,
  input  logic [1:0]       mode,
  input  logic             shb,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] qb,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  // One shift step of the current contents; mode is re-evaluated every step.
  always_comb begin
    step_q   = qb;
    step_out = qb[0];
    unique case (mode)
      2'b00: begin
        step_q   = {sin, qb[WIDTH-1:1]};
        step_out = qb[0];
      end
      2'b01: begin
        step_q   = {qb[WIDTH-2:0], sin};
        step_out = qb[WIDTH-1];
      end
      2'b10: begin
        step_q   = {qb[WIDTH-1], qb[WIDTH-1:1]};
        step_out = qb[0];
      end
      2'b11: begin
        step_q   = {qb[0], qb[WIDTH-1:1]};
        step_out = qb[0];
      end
      default: begin
        step_q   = qb;
        step_out = qb[0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      qb    <= '0;
      sout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      unique case (state)
        SHIFT: begin
          if (ld) begin
            // Abort: load wins, no step on this edge, and no completion pulse.
            qb    <= db;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            qb   <= step_q;
            sout <= step_out;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
          if (ld) begin
            qb <= db;
          end else if (start) begin
            if (amt != '0) begin
              cnt   <= amt;
              busy  <= 1'b1;
              state <= SHIFT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (shb) begin
            qb   <= step_q;
            sout <= step_out;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_shift_reg.sv
// Directed bench for mult_shift_reg (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_mult_shift_reg;

  logic       clk = 1'b0;
  logic       clr;
  logic       ld;
  logic [7:0] db;
  logic [1:0] mode;
  logic       shb;
  logic       start;
  logic [3:0] amt;
  logic       sin;
  logic [7:0] qb;
  logic       sout;
  logic       busy;
  logic       done;

  int checks = 0;
  int passed = 0;
  int nbusy;
  int ndone;

  mult_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .ld(ld), .db(db), .mode(mode), .shb(shb),
    .start(start), .amt(amt), .sin(sin), .qb(qb), .sout(sout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input logic [7:0] v);
    ld = 1'b1;
    db = v;
    tick();
    ld = 1'b0;
  endtask

  // Issue start, then run until busy drops (bounded), counting busy cycles.
  task automatic run_seq(input logic [3:0] a, input logic [1:0] m, input logic s);
    start = 1'b1;
    amt   = a;
    mode  = m;
    sin   = s;
    tick();
    start = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      nbusy++;
      tick();
    end
  endtask

  initial begin
    clr = 1'b1; ld = 1'b0; db = '0; mode = 2'b00; shb = 1'b0;
    start = 1'b0; amt = '0; sin = 1'b0;
    #12;
    check("rst_qb", 32'(qb), 32'h0);
    check("rst_flags", {29'b0, sout, busy, done}, 32'h0);
    clr = 1'b0;
    tick();

    // 1: logical right 3
    load(8'hA5);
    check("t1_load", 32'(qb), 32'hA5);
    run_seq(4'd3, 2'b00, 1'b0);
    check("t1_busy_cycles", 32'(nbusy), 32'd3);
    check("t1_done", 32'(done), 32'd1);
    check("t1_qb", 32'(qb), 32'h14);
    check("t1_sout", 32'(sout), 32'd1);
    tick();
    check("t1_done_drop", 32'(done), 32'd0);

    // 2: arithmetic right 2
    load(8'h90);
    run_seq(4'd2, 2'b10, 1'b0);
    check("t2_busy_cycles", 32'(nbusy), 32'd2);
    check("t2_qb", 32'(qb), 32'hE4);
    check("t2_sout", 32'(sout), 32'd0);
    ndone = int'(done);
    tick();
    ndone += int'(done);
    check("t2_done_once", 32'(ndone), 32'd1);

    // 3: rotate right 9 wraps to 1
    load(8'h81);
    run_seq(4'd9, 2'b11, 1'b0);
    check("t3_busy_cycles", 32'(nbusy), 32'd9);
    check("t3_qb", 32'(qb), 32'hC0);
    check("t3_sout", 32'(sout), 32'd1);
    tick();

    // 4: two single-step logical lefts, sin=1
    load(8'h0F);
    mode = 2'b01; sin = 1'b1; shb = 1'b1;
    tick();
    check("t4_step1", 32'(qb), 32'h1F);
    tick();
    shb = 1'b0;
    check("t4_qb", 32'(qb), 32'h3F);
    check("t4_flags", {29'b0, sout, busy, done}, 32'h0);

    // 5: async clear mid-sequence
    load(8'hFF);
    start = 1'b1; amt = 4'd5; mode = 2'b00; sin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t5_mid_qb", 32'(qb), 32'h3F);
    check("t5_mid_busy", 32'(busy), 32'd1);
    #2 clr = 1'b1;
    #1;
    check("t5_clr_qb", 32'(qb), 32'h0);
    check("t5_clr_flags", {29'b0, sout, busy, done}, 32'h0);
    #1 clr = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ndone += int'(done) + int'(busy);
    end
    check("t5_no_done", 32'(ndone), 32'd0);

    // 6a: amt=0 completes immediately
    load(8'h3C);
    run_seq(4'd0, 2'b00, 1'b0);
    check("t6a_busy_cycles", 32'(nbusy), 32'd0);
    check("t6a_done", 32'(done), 32'd1);
    check("t6a_qb", 32'(qb), 32'h3C);
    tick();
    check("t6a_done_drop", 32'(done), 32'd0);

    // 6b: ld beats start
    ld = 1'b1; start = 1'b1; amt = 4'd4; db = 8'h5A;
    tick();
    ld = 1'b0; start = 1'b0;
    check("t6b_qb", 32'(qb), 32'h5A);
    check("t6b_flags", {30'b0, busy, done}, 32'h0);
    tick();
    check("t6b_idle", {30'b0, busy, done}, 32'h0);

    // 6c: ld aborts a running sequence
    run_seq_start_only();
    check("t6c_step1", 32'(qb), 32'h2D);
    ld = 1'b1; db = 8'h77;
    tick();
    ld = 1'b0;
    check("t6c_qb", 32'(qb), 32'h77);
    check("t6c_flags", {30'b0, busy, done}, 32'h0);
    tick();
    check("t6c_no_done", {30'b0, busy, done}, 32'h0);

    // Saturation: arith right 12 of 0xF0 -> all ones; logical left 15 -> zero
    load(8'hF0);
    run_seq(4'd12, 2'b10, 1'b0);
    check("sat_arith_qb", 32'(qb), 32'hFF);
    check("sat_arith_sout", 32'(sout), 32'd1);
    tick();
    run_seq(4'd15, 2'b01, 1'b0);
    check("sat_left_busy", 32'(nbusy), 32'd15);
    check("sat_left_qb", 32'(qb), 32'h00);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Start a 4-step logical right on 0x5A and stop after the first shift.
  task automatic run_seq_start_only();
    start = 1'b1; amt = 4'd4; mode = 2'b00; sin = 1'b0;
    tick();
    start = 1'b0;
    tick();
  endtask

endmodule
